neopixel_frame_sched: RTL and testbench

Frame scheduler that sits between the host-side color logic and `neopixel_tx_fsm`. It keeps a double-buffered pixel store, and starts a frame when a frame tick arrives. It then streams `NPIX` pixel messages, followed by `RESET_MSGS` latch (reset) messages, into the transmitter, and returns to idle. Color writes never tear a frame: the whole shadow buffer becomes visible only at a frame boundary.

---
 rtl/neopixel_frame_sched.sv | 91 +++++++++
 tb/tb_neopixel_frame_sched.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/neopixel_frame_sched.sv
// neopixel_frame_sched: double-buffered pixel store that streams one frame of pixel
// messages plus latch messages into the NeoPixel transmitter per frame tick.
module neopixel_frame_sched #(
   parameter int NPIX       = 18,
   parameter int RESET_MSGS = 14,
   parameter int IDX_W      = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             frame_tick,
   input  logic             wr_en,
   input  logic [IDX_W-1:0] wr_addr,
   input  logic [23:0]      wr_data,
   input  logic             commit,
   input  logic             tx_rd_next,
   output logic             tx_enable,
   output logic [23:0]      tx_data,
   output logic             tx_msgTyp,
   output logic             busy,
   output logic             commit_pending,
   output logic             frame_done,
   output logic             overrun
);
   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] PIXELS = 2'd1;
   localparam logic [1:0] LATCH  = 2'd2;
   localparam logic [IDX_W-1:0] NPIX_M1 = IDX_W'(NPIX - 1);
   localparam logic [IDX_W-1:0] LAT_M1  = IDX_W'(RESET_MSGS - 1);

   logic [1:0]       state;
   logic [IDX_W-1:0] pos, lat;
   logic             half, tick_pend;
   logic [23:0]      shadow [NPIX];
   logic [23:0]      active [NPIX];

   assign busy      = state != IDLE;
   assign tx_enable = busy;
   assign tx_msgTyp = state == PIXELS;
   assign tx_data   = state == PIXELS ? active[pos] : 24'h0;

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state          <= IDLE;
         pos            <= '0;
         lat            <= '0;
         half           <= 1'b0;
         tick_pend      <= 1'b0;
         commit_pending <= 1'b0;
         frame_done     <= 1'b0;
         overrun        <= 1'b0;
         shadow         <= '{default: '0};
         active         <= '{default: '0};
      end else begin
         frame_done <= 1'b0;
         overrun    <= 1'b0;
         if (wr_en && wr_addr <= NPIX_M1) shadow[wr_addr] <= wr_data;
         if (commit) commit_pending <= 1'b1;
         if (state == IDLE) begin
            half <= 1'b0;
            if (frame_tick | tick_pend) begin
               tick_pend <= 1'b0;
               pos       <= '0;
               state     <= PIXELS;
               // copy sees pre-edge shadow; a commit on this same edge stays pending
               if (commit_pending) begin
                  active <= shadow;
                  if (!commit) commit_pending <= 1'b0;
               end
            end
         end else begin
            if (frame_tick) begin
               if (tick_pend) overrun <= 1'b1;
               else tick_pend <= 1'b1;
            end
            if (tx_rd_next) begin
               half <= ~half;
               if (half) begin
                  if (state == PIXELS) begin
                     if (pos == NPIX_M1) begin
                        state <= LATCH;
                        lat   <= '0;
                     end else pos <= pos + 1'b1;
                  end else if (lat == LAT_M1) begin
                     state      <= IDLE;
                     frame_done <= 1'b1;
                  end else lat <= lat + 1'b1;
               end
            end
         end
      end
endmodule

// File: tb/tb_neopixel_frame_sched.sv
// tb_neopixel_frame_sched: directed bench with a scoreboard of expected messages
// pushed at each modelled frame start and popped as the transmitter model reads.
module tb_neopixel_frame_sched;
   localparam int NPIX = 18;
   localparam int RESET_MSGS = 14;

   logic        clk = 1'b0, rst = 1'b1;
   logic        frame_tick = 1'b0, wr_en = 1'b0, commit = 1'b0, tx_rd_next = 1'b0;
   logic [4:0]  wr_addr = '0;
   logic [23:0] wr_data = '0;
   logic        tx_enable, tx_msgTyp, busy, commit_pending, frame_done, overrun;
   logic [23:0] tx_data;

   int tests = 0, fails = 0;
   logic [23:0] sh [NPIX];
   logic [23:0] ac [NPIX];
   logic        cp = 1'b0;
   logic [24:0] q [$];

   neopixel_frame_sched dut (
      .clk(clk), .rst(rst), .frame_tick(frame_tick), .wr_en(wr_en), .wr_addr(wr_addr),
      .wr_data(wr_data), .commit(commit), .tx_rd_next(tx_rd_next), .tx_enable(tx_enable),
      .tx_data(tx_data), .tx_msgTyp(tx_msgTyp), .busy(busy), .commit_pending(commit_pending),
      .frame_done(frame_done), .overrun(overrun)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(negedge clk);
   endtask

   task automatic model_reset();
      for (int i = 0; i < NPIX; i++) begin sh[i] = '0; ac[i] = '0; end
      cp = 1'b0;
      q.delete();
   endtask

   task automatic model_start();
      if (cp) for (int i = 0; i < NPIX; i++) ac[i] = sh[i];
      cp = 1'b0;
      for (int i = 0; i < NPIX; i++) q.push_back({1'b1, ac[i]});
      for (int i = 0; i < RESET_MSGS; i++) q.push_back({1'b0, 24'h0});
   endtask

   task automatic write(input logic [4:0] a, input logic [23:0] d);
      wr_en = 1'b1; wr_addr = a; wr_data = d;
      cyc();
      wr_en = 1'b0;
      if (a < NPIX) sh[a] = d;
   endtask

   task automatic do_commit();
      commit = 1'b1;
      cyc();
      commit = 1'b0;
      cp = 1'b1;
   endtask

   task automatic tick();
      frame_tick = 1'b1;
      cyc();
      frame_tick = 1'b0;
   endtask

   task automatic run_msgs(input int n);
      logic [24:0] e;
      for (int m = 0; m < n; m++) begin
         if (q.size() == 0) begin
            check("scoreboard_empty", 32'd1, 32'd0);
            return;
         end
         e = q.pop_front();
         check($sformatf("en_%0d", m), tx_enable, 1'b1);
         check($sformatf("typ_%0d", m), tx_msgTyp, e[24]);
         check($sformatf("data_%0d", m), tx_data, e[23:0]);
         tx_rd_next = 1'b1; cyc(); tx_rd_next = 1'b0;
         check($sformatf("hold_%0d", m), tx_data, e[23:0]);
         cyc();
         tx_rd_next = 1'b1; cyc(); tx_rd_next = 1'b0;
      end
   endtask

   task automatic end_frame(input string tag);
      check({tag, "_done"}, frame_done, 1'b1);
      check({tag, "_busy"}, busy, 1'b0);
      check({tag, "_en"}, tx_enable, 1'b0);
   endtask

   initial begin
      model_reset();
      repeat (3) cyc();
      check("rst_en", tx_enable, 1'b0);
      check("rst_data", tx_data, 24'h0);
      check("rst_typ", tx_msgTyp, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_cp", commit_pending, 1'b0);
      check("rst_done", frame_done, 1'b0);
      check("rst_ovr", overrun, 1'b0);
      rst = 1'b0;
      cyc();
      // single frame
      for (int i = 0; i < NPIX; i++) write(5'(i), 24'h010000 * i);
      do_commit();
      check("cp_set", commit_pending, 1'b1);
      tx_rd_next = 1'b1; cyc(); tx_rd_next = 1'b0;
      check("idle_rd_ignored", busy, 1'b0);
      model_start();
      tick();
      check("f1_cp_clear", commit_pending, 1'b0);
      run_msgs(NPIX + RESET_MSGS);
      end_frame("f1");
      cyc();
      check("f1_done_pulse", frame_done, 1'b0);
      // no tearing + tick queueing
      model_start();
      tick();
      write(5'd0, 24'hFFFFFF);
      do_commit();
      tick();
      check("pend_no_ovr", overrun, 1'b0);
      tick();
      check("ovr_pulse", overrun, 1'b1);
      cyc();
      check("ovr_one_cycle", overrun, 1'b0);
      check("cp_mid", commit_pending, 1'b1);
      run_msgs(NPIX + RESET_MSGS);
      end_frame("f2");
      check("cp_until_start", commit_pending, 1'b1);
      model_start();
      cyc();
      check("f3_autostart", tx_enable, 1'b1);
      check("f3_cp_clear", commit_pending, 1'b0);
      run_msgs(NPIX + RESET_MSGS);
      end_frame("f3");
      repeat (4) cyc();
      check("two_frames_only", busy, 1'b0);
      model_start();
      tick();
      run_msgs(NPIX + RESET_MSGS);
      end_frame("f4");
      // simultaneous commit + write + tick in IDLE
      write(5'd3, 24'h111111);
      do_commit();
      model_start();
      wr_en = 1'b1; wr_addr = 5'd3; wr_data = 24'hABCDEF; commit = 1'b1; frame_tick = 1'b1;
      cyc();
      wr_en = 1'b0; commit = 1'b0; frame_tick = 1'b0;
      sh[3] = 24'hABCDEF;
      cp = 1'b1;
      check("sim_cp_kept", commit_pending, 1'b1);
      run_msgs(NPIX + RESET_MSGS);
      end_frame("f5");
      check("sim_cp_after", commit_pending, 1'b1);
      model_start();
      tick();
      run_msgs(NPIX + RESET_MSGS);
      end_frame("f6");
      // reset mid-frame, then out-of-range writes
      model_start();
      tick();
      run_msgs(7);
      rst = 1'b1;
      #1;
      check("arst_en", tx_enable, 1'b0);
      check("arst_data", tx_data, 24'h0);
      check("arst_typ", tx_msgTyp, 1'b0);
      check("arst_busy", busy, 1'b0);
      model_reset();
      cyc(); cyc();
      rst = 1'b0;
      cyc();
      write(5'd18, 24'h123456);
      write(5'd31, 24'hABCDEF);
      do_commit();
      model_start();
      tick();
      run_msgs(NPIX + RESET_MSGS);
      end_frame("f7");
      check("sb_drained", q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL timeout tests=%0d", tests);
      $fatal(1, "timeout");
   end
endmodule
